// File: rtl/mem_arbiter.sv
// Two-requester main-memory arbiter: the I-cache fill path and the D-cache fill/write-back path share one memory port.
// Define MEM_ARB_RR_EN for round-robin tie-breaking; without it the D-cache has fixed priority.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic              ic_ack,
  output logic [LINE_W-1:0] ic_rdata,
  input  logic              dc_req,
  input  logic              dc_we,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [LINE_W-1:0] dc_wdata,
  output logic              dc_ack,
  output logic [LINE_W-1:0] dc_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, SERVE, RESP} state_t;

  state_t state, state_d;
  logic   owner_dc;
  logic   grant_dc;

`ifdef MEM_ARB_RR_EN
  logic last_dc;  // 0 = I-cache owned the previous grant

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                  last_dc <= 1'b0;
    else if (state == IDLE && (ic_req || dc_req)) last_dc <= grant_dc;
  end

  always_comb begin
    grant_dc = dc_req;
    if (dc_req && ic_req) grant_dc = !last_dc;
  end
`else
  always_comb grant_dc = dc_req;
`endif

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (ic_req || dc_req) state_d = SERVE;
      SERVE:   if (mem_ready)        state_d = RESP;
      RESP:                          state_d = IDLE;
      default:                       state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  // Every output is a register; requester inputs are only looked at in IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_dc  <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      ic_ack    <= 1'b0;
      dc_ack    <= 1'b0;
      ic_rdata  <= '0;
      dc_rdata  <= '0;
      busy      <= 1'b0;
    end else begin
      ic_ack <= 1'b0;
      dc_ack <= 1'b0;
      busy   <= (state_d != IDLE);
      case (state)
        IDLE: if (ic_req || dc_req) begin
          owner_dc  <= grant_dc;
          mem_req   <= 1'b1;
          mem_we    <= grant_dc & dc_we;
          mem_addr  <= grant_dc ? dc_addr : ic_addr;
          mem_wdata <= grant_dc ? dc_wdata : '0;
        end
        SERVE: if (mem_ready) begin
          mem_req <= 1'b0;
          if (owner_dc) dc_ack <= 1'b1;
          else          ic_ack <= 1'b1;
          if (!mem_we) begin
            if (owner_dc) dc_rdata <= mem_rdata;
            else          ic_rdata <= mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fills, write-back, arbitration, zero-wait streaming, reset abort.
module tb_mem_arbiter;
  localparam int ADDR_W = 32;
  localparam int LINE_W = 128;

  logic              clk = 1'b0;
  logic              reset;
  logic              ic_req, dc_req, dc_we, mem_ready;
  logic [ADDR_W-1:0] ic_addr, dc_addr;
  logic [LINE_W-1:0] dc_wdata, mem_rdata;
  logic              ic_ack, dc_ack, mem_req, mem_we, busy;
  logic [LINE_W-1:0] ic_rdata, dc_rdata, mem_wdata;
  logic [ADDR_W-1:0] mem_addr;

  int total = 0;
  int bad   = 0;

  mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk(clk), .reset(reset),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_ack(ic_ack), .ic_rdata(ic_rdata),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_ack(dc_ack), .dc_rdata(dc_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Both caches request reads together and hold until their own ack.
  task automatic pair(input logic first_dc, input logic [LINE_W-1:0] ra, input logic [LINE_W-1:0] rb);
    ic_req = 1; ic_addr = 32'h140; dc_req = 1; dc_we = 0; dc_addr = 32'h240;
    mem_ready = 1; mem_rdata = ra;
    tick(); chk("pair_addr1", mem_addr, first_dc ? 32'h240 : 32'h140);
    tick();
    chk("pair_ack1_dc", dc_ack, first_dc);
    chk("pair_ack1_ic", ic_ack, !first_dc);
    chk("pair_rd1", first_dc ? dc_rdata : ic_rdata, ra);
    if (first_dc) dc_req = 0; else ic_req = 0;
    mem_rdata = rb;
    tick(); chk("pair_idle", busy, 1'b0);
    tick(); chk("pair_addr2", mem_addr, first_dc ? 32'h140 : 32'h240);
    tick();
    chk("pair_ack2_dc", dc_ack, !first_dc);
    chk("pair_ack2_ic", ic_ack, first_dc);
    chk("pair_rd2", first_dc ? ic_rdata : dc_rdata, rb);
    ic_req = 0; dc_req = 0; mem_ready = 0;
    tick();
  endtask

  initial begin
    logic [LINE_W-1:0] pat_a, pat_b;
    pat_a = {4{32'hAAAA_AAAA}};
    pat_b = {4{32'h5A5A_0F0F}};
    reset = 1; ic_req = 0; dc_req = 0; dc_we = 0; mem_ready = 0;
    ic_addr = '0; dc_addr = '0; dc_wdata = '0; mem_rdata = '0;
    tick(); tick();
    chk("rst_mem_req", mem_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_acks", {ic_ack, dc_ack}, 0);
    chk("rst_ic_rdata", ic_rdata, 0);
    chk("rst_dc_rdata", dc_rdata, 0);
    chk("rst_mem_addr", mem_addr, 0);
    reset = 0;
    tick();

    // I-cache fill, 3 mem_req cycles before ready; address change after grant
    ic_req = 1; ic_addr = 32'h100;
    tick();
    chk("t1_mem_req", mem_req, 1);
    chk("t1_mem_addr", mem_addr, 32'h100);
    chk("t1_mem_we", mem_we, 0);
    chk("t1_busy", busy, 1);
    ic_addr = 32'h500;
    tick();
    chk("t6_addr_hold", mem_addr, 32'h100);
    chk("t1_no_ack", ic_ack, 0);
    tick();
    chk("t6_addr_hold2", mem_addr, 32'h100);
    mem_ready = 1; mem_rdata = pat_a;
    tick();
    chk("t1_ic_ack", ic_ack, 1);
    chk("t1_dc_ack", dc_ack, 0);
    chk("t1_ic_rdata", ic_rdata, pat_a);
    chk("t1_mem_req_off", mem_req, 0);
    ic_req = 0; mem_ready = 0;
    tick();
    chk("t1_ack_pulse", ic_ack, 0);
    chk("t1_idle", busy, 0);

    // D-cache write-back
    dc_req = 1; dc_we = 1; dc_addr = 32'h200; dc_wdata = 128'h1234;
    tick();
    chk("t2_mem_we", mem_we, 1);
    chk("t2_mem_wdata", mem_wdata, 128'h1234);
    chk("t2_mem_addr", mem_addr, 32'h200);
    mem_ready = 1; mem_rdata = 128'hDEAD;
    tick();
    chk("t2_dc_ack", dc_ack, 1);
    chk("t2_ic_ack", ic_ack, 0);
    chk("t2_dc_rdata", dc_rdata, 0);
    dc_req = 0; dc_we = 0; mem_ready = 0;
    tick();
    chk("t2_ack_pulse", dc_ack, 0);

    // Simultaneous requests; last grant was dc
`ifdef MEM_ARB_RR_EN
    pair(1'b0, pat_b, pat_a);
    pair(1'b0, pat_a, pat_b);
`else
    pair(1'b1, pat_b, pat_a);
    pair(1'b1, pat_a, pat_b);
`endif

    // Zero-wait streaming: 3-cycle period
    ic_req = 1; ic_addr = 32'h180; mem_ready = 1; mem_rdata = pat_b;
    for (int k = 1; k <= 9; k++) begin
      tick();
      chk($sformatf("t4_mem_req_%0d", k), mem_req, (k % 3) == 1);
      chk($sformatf("t4_ic_ack_%0d", k), ic_ack, (k % 3) == 2);
    end
    ic_req = 0; mem_ready = 0;
    chk("t4_ic_rdata", ic_rdata, pat_b);
    tick();

    // Reset during SERVE aborts
    dc_req = 1; dc_we = 0; dc_addr = 32'h280;
    tick();
    chk("t5_serve", mem_req, 1);
    reset = 1;
    #1;
    chk("t5_async_req", mem_req, 0);
    chk("t5_async_busy", busy, 0);
    chk("t5_rdata_clr", ic_rdata, 0);
    dc_req = 0;
    tick();
    reset = 0;
    tick();
    chk("t5_no_ack", {ic_ack, dc_ack}, 0);
    chk("t5_still_idle", busy, 0);
    dc_req = 1; dc_addr = 32'h300; mem_ready = 1; mem_rdata = pat_a;
    tick();
    chk("t5_addr", mem_addr, 32'h300);
    chk("t5_req", mem_req, 1);
    tick();
    chk("t5_dc_ack", dc_ack, 1);
    chk("t5_dc_rdata", dc_rdata, pat_a);
    dc_req = 0; mem_ready = 0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares the single main-memory port between the instruction-cache miss path (fetch stage) and the data-cache miss/write-back path (memory stage). It grants one requester at a time and sequences a request/ready transaction on the memory side. It returns a one-cycle acknowledge plus line data to the owner. Fetch and memory stages keep their stall requests asserted until they see their acknowledge.

Parameters:
ADDR_W, 32, memory address width
LINE_W, 128, cache line / memory data width

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
ic_req  in  1  I-cache line-fill request (level)
ic_addr  in  ADDR_W  I-cache fill address
ic_ack  out  1  I-cache transaction complete (1-cycle pulse)
ic_rdata  out  LINE_W  I-cache fill data
dc_req  in  1  D-cache request (level)
dc_we  in  1  1 = write-back, 0 = line fill
dc_addr  in  ADDR_W  D-cache address
dc_wdata  in  LINE_W  D-cache write-back data
dc_ack  out  1  D-cache transaction complete (1-cycle pulse)
dc_rdata  out  LINE_W  D-cache fill data
mem_req  out  1  memory request, held until mem_ready
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  LINE_W  memory write data
mem_rdata  in  LINE_W  memory read data, valid with mem_ready
mem_ready  in  1  memory completes the current request
busy  out  1  arbiter not in IDLE

Behaviour:
- Reset: state IDLE; all outputs 0, including both rdata registers. Reset mid-transaction aborts: mem_req drops immediately (async), no ack is issued, and latched request data is discarded.
- All outputs are registered. Nothing is driven combinationally from inputs.
- FSM states: IDLE, SERVE, RESP.
- IDLE:
  - If any req is high, pick a winner, latch owner, addr, we and wdata, then go to SERVE.
  - The winner's we comes from dc_we; the I-cache is always a read with wdata 0.
  - Default priority: dc beats ic.
  - If no req is high, stay in IDLE.
- SERVE:
  - mem_req=1. mem_we, mem_addr and mem_wdata stay stable from the latched values.
  - Requester inputs are ignored after the grant, including address or data changes.
  - On a cycle with mem_ready=1: for a read, capture mem_rdata into the owner's rdata register; set the owner's ack; clear mem_req; go to RESP.
  - A write leaves the owner's rdata unchanged.
- RESP:
  - Owner's ack=1 for exactly this cycle; the other ack stays 0.
  - Requests are not sampled; go to IDLE.
- Requester rule: req still high in the cycle after ack is treated as a new request.
- mem_ready outside SERVE is ignored.
- rdata outputs hold their value until the next completed read for that requester.
- Latency: if a req is sampled in IDLE at cycle t, mem_req is high in t+1. If mem_ready arrives in cycle t+k (k≥1), ack is high in t+k+1. Back-to-back period with zero-wait memory is 3 cycles.
- busy = (state != IDLE).
- Addresses pass through unmodified; there is no alignment check.

Optional Feature:
MEM_ARB_RR_EN
- Defined: a last_owner register (reset value = I-cache) is updated at each grant. On simultaneous requests in IDLE, the requester not granted last wins. The first tie after reset goes to dc.
- Undefined: fixed priority; dc always wins ties, and the I-cache can starve under continuous dc traffic.

Test Plan:
1. I-cache fill: ic_req=1, ic_addr=0x100; mem_ready after 3 mem_req cycles with mem_rdata=0xAAAA_..._AAAA -> mem_addr=0x100, mem_we=0, ic_ack one cycle, ic_rdata=0xAAAA_..._AAAA, dc_ack=0.
2. D-cache write-back: dc_req=1, dc_we=1, addr 0x200, wdata 0x1234 -> mem_we=1, mem_wdata=0x1234, dc_ack pulse, dc_rdata unchanged.
3. Simultaneous ic_req and dc_req held until their acks -> dc served first, then ic. With MEM_ARB_RR_EN, a second simultaneous pair (after dc's prior win) grants ic first.
4. mem_ready tied 1 with ic_req held continuously -> ic_ack pulses every 3 cycles; mem_req high 1 cycle of every 3.
5. Reset asserted during SERVE -> mem_req=0 immediately, no ack, busy=0. After release, a dc read of 0x300 completes normally.
6. ic_addr changed from 0x100 to 0x500 after grant, during SERVE -> mem_addr remains 0x100 until ack.
